// File: rtl/agc_alu_seq_pkg.sv
// +----------------------------------------------------------------------------+
// | agc_alu_pkg                                                                |
// | Shared types, widths and ones'-complement helpers for agc_alu_seq.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package agc_alu_pkg;

  localparam int WORD_W  = 15;
  localparam int DWORD_W = 30;

  localparam logic [WORD_W-1:0] POS_ZERO = 15'h0000;
  localparam logic [WORD_W-1:0] NEG_ZERO = 15'h7FFF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } seq_state_e;

  function automatic logic signed [31:0] oc15_to_int(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? -$signed({17'd0, ~v}) : $signed({17'd0, v});
  endfunction

  function automatic logic signed [31:0] oc30_to_int(input logic [DWORD_W-1:0] v);
    return v[DWORD_W-1] ? -$signed({2'd0, ~v}) : $signed({2'd0, v});
  endfunction

  // Negative values map to (v - 1) modulo 2^N; MSB of the result is underflow.
  function automatic logic [WORD_W:0] int_to_oc15(input logic signed [31:0] v);
    return {(v < -32'sd16383), v[WORD_W-1:0] - {14'd0, v[31]}};
  endfunction

  function automatic logic [DWORD_W:0] int_to_oc30(input logic signed [31:0] v);
    return {(v < -32'sd536870911), v[DWORD_W-1:0] - {29'd0, v[31]}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/agc_alu_seq_if.sv
// +----------------------------------------------------------------------------+
// | agc_alu_seq_if                                                             |
// | Request/response bundle between the two requesters and the ALU sequencer. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface agc_alu_seq_if;
  import agc_alu_pkg::*;

  logic [1:0]                req_valid;
  logic [1:0]                req_ready;
  logic [1:0][1:0]           req_op;
  logic [1:0][DWORD_W-1:0]   req_a;
  logic [1:0][WORD_W-1:0]    req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic                      rsp_id;
  logic [WORD_W-1:0]         rsp_hi;
  logic [WORD_W-1:0]         rsp_lo;
  logic                      rsp_uflow;
  logic                      rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_uflow, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_hi, rsp_lo, rsp_uflow, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/agc_alu_seq_rr_arb2.sv
// +----------------------------------------------------------------------------+
// | rr_arb2                                                                    |
// | Two-way round-robin grant; pointer moves only on an accepted handshake.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arb2 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] i_req,
  input  wire logic       i_accept,
  input  wire logic       i_accept_id,
  output logic      [1:0] o_grant
);

  // r_ptr names the requester that wins a tie.
  logic r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_accept) begin
      r_ptr <= ~i_accept_id;
    end
  end

  always_comb begin
    o_grant = 2'b00;
    if (i_req[r_ptr]) begin
      o_grant[r_ptr] = 1'b1;
    end else if (i_req[~r_ptr]) begin
      o_grant[~r_ptr] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/agc_alu_seq.sv
// +----------------------------------------------------------------------------+
// | agc_alu_seq                                                                |
// | Arbitrates two requesters onto one AGC ones'-complement ALU with           |
// | multicycle operand hold. Divider present only with AGC_ALU_SEQ_DIV_EN.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module agc_alu_seq
  import agc_alu_pkg::*;
#(
  parameter int ADD_CYC = 1,
  parameter int MUL_CYC = 2,
  parameter int DIV_CYC = 4
) (
  input  wire logic     clk,
  input  wire logic     rst,
  agc_alu_seq_if.slave  bus
);

  localparam int MAX_CYC = (ADD_CYC > MUL_CYC)
                         ? ((ADD_CYC > DIV_CYC) ? ADD_CYC : DIV_CYC)
                         : ((MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC);
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  seq_state_e         r_state;
  logic [CNT_W-1:0]   r_cnt;
  alu_op_e            r_op;
  logic [DWORD_W-1:0] r_a;
  logic [WORD_W-1:0]  r_b;
  logic               r_id;
  logic [1:0]         r_req_ready;
  logic               r_rsp_valid;
  logic               r_rsp_id;
  logic [WORD_W-1:0]  r_rsp_hi;
  logic [WORD_W-1:0]  r_rsp_lo;
  logic               r_rsp_uflow;
  logic               r_rsp_err;

  logic               w_hs;
  logic               w_hs_id;
  logic [1:0]         w_grant;
  alu_op_e            w_sel_op;
  logic [WORD_W-1:0]  w_sel_b;
  logic               w_bypass;
  logic [CNT_W-1:0]   w_cnt_load;

  // req_ready is only ever non-zero in IDLE, so no state qualifier is needed.
  assign w_hs     = |(bus.req_valid & r_req_ready);
  assign w_hs_id  = r_req_ready[1];
  assign w_sel_op = alu_op_e'(bus.req_op[w_hs_id]);
  assign w_sel_b  = bus.req_b[w_hs_id];

`ifdef AGC_ALU_SEQ_DIV_EN
  assign w_bypass = (w_sel_op == OP_DIV) && ((w_sel_b == POS_ZERO) || (w_sel_b == NEG_ZERO));
`else
  assign w_bypass = (w_sel_op == OP_DIV);
`endif

  always_comb begin
    w_cnt_load = CNT_W'(ADD_CYC - 1);
    case (w_sel_op)
      OP_MUL:  w_cnt_load = CNT_W'(MUL_CYC - 1);
      OP_DIV:  w_cnt_load = CNT_W'(DIV_CYC - 1);
      default: ;
    endcase
  end

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (bus.req_valid),
    .i_accept    (w_hs),
    .i_accept_id (w_hs_id),
    .o_grant     (w_grant)
  );

  // Add/subtract with end-around carry; -0 results are left as-is.
  logic [WORD_W-1:0] w_addend;
  logic [WORD_W:0]   w_add_raw;
  logic [WORD_W-1:0] w_sum;

  assign w_addend  = (r_op == OP_SUB) ? ~r_b : r_b;
  assign w_add_raw = {1'b0, r_a[WORD_W-1:0]} + {1'b0, w_addend};
  assign w_sum     = w_add_raw[WORD_W-1:0] + {14'd0, w_add_raw[WORD_W]};

  logic signed [31:0] w_mul_p;
  logic [DWORD_W:0]   w_mul_oc;

  assign w_mul_p  = oc15_to_int(r_a[WORD_W-1:0]) * oc15_to_int(r_b);
  assign w_mul_oc = int_to_oc30(w_mul_p);

`ifdef AGC_ALU_SEQ_DIV_EN
  logic signed [31:0] w_num;
  logic signed [31:0] w_den;
  logic signed [31:0] w_quo;
  logic signed [31:0] w_rem;
  logic [WORD_W:0]    w_quo_oc;
  logic [WORD_W:0]    w_rem_oc;

  assign w_num    = oc30_to_int(r_a);
  assign w_den    = oc15_to_int(r_b);
  assign w_quo    = (w_den == 32'sd0) ? 32'sd0 : (w_num / w_den);
  assign w_rem    = (w_den == 32'sd0) ? 32'sd0 : (w_num % w_den);
  assign w_quo_oc = int_to_oc15(w_quo);
  assign w_rem_oc = int_to_oc15(w_rem);
`else
  logic w_unused_a;
  assign w_unused_a = &{1'b0, r_a[DWORD_W-1:WORD_W]};
`endif

  logic [WORD_W-1:0] w_res_hi;
  logic [WORD_W-1:0] w_res_lo;
  logic              w_res_uflow;

  always_comb begin
    w_res_hi    = '0;
    w_res_lo    = w_sum;
    w_res_uflow = 1'b0;
    case (r_op)
      OP_MUL: begin
        w_res_hi    = w_mul_oc[DWORD_W-1:WORD_W];
        w_res_lo    = w_mul_oc[WORD_W-1:0];
        w_res_uflow = w_mul_oc[DWORD_W];
      end
`ifdef AGC_ALU_SEQ_DIV_EN
      OP_DIV: begin
        w_res_hi    = w_quo_oc[WORD_W-1:0];
        w_res_lo    = w_rem_oc[WORD_W-1:0];
        w_res_uflow = w_quo_oc[WORD_W] | w_rem_oc[WORD_W];
      end
`endif
      default: ;
    endcase
  end

  // Ready is registered, so it is pre-computed on every edge that lands in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= 1'b0;
      r_req_ready <= 2'b00;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_hi    <= '0;
      r_rsp_lo    <= '0;
      r_rsp_uflow <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_req_ready <= 2'b00;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            if (w_bypass) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_id    <= w_hs_id;
              r_rsp_hi    <= '0;
              r_rsp_lo    <= '0;
              r_rsp_uflow <= 1'b0;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= ST_EXEC;
              r_op    <= w_sel_op;
              r_a     <= bus.req_a[w_hs_id];
              r_b     <= w_sel_b;
              r_id    <= w_hs_id;
              r_cnt   <= w_cnt_load;
            end
          end else begin
            r_req_ready <= w_grant;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_hi    <= w_res_hi;
            r_rsp_lo    <= w_res_lo;
            r_rsp_uflow <= w_res_uflow;
            r_rsp_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= w_grant;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_hi    = r_rsp_hi;
  assign bus.rsp_lo    = r_rsp_lo;
  assign bus.rsp_uflow = r_rsp_uflow;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_agc_alu_seq.sv
// +----------------------------------------------------------------------------+
// | tb_agc_alu_seq                                                             |
// | Directed self-checking bench for agc_alu_seq (both AGC_ALU_SEQ_DIV_EN      |
// | builds). Rev 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_agc_alu_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  agc_alu_seq_if bus_if ();

  agc_alu_seq #(
    .ADD_CYC (1),
    .MUL_CYC (2),
    .DIV_CYC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic id, input logic [1:0] op,
                       input logic [29:0] a, input logic [14:0] b,
                       input logic [14:0] e_hi, input logic [14:0] e_lo,
                       input logic e_err, input logic e_uflow, input int e_lat);
    int n;
    bus_if.req_valid     = 2'b00;
    bus_if.req_valid[id] = 1'b1;
    bus_if.req_op[id]    = op;
    bus_if.req_a[id]     = a;
    bus_if.req_b[id]     = b;
    n = 0;
    while (!bus_if.req_ready[id] && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".ready"}, {30'd0, bus_if.req_ready}, id ? 32'd2 : 32'd1);
    step();
    bus_if.req_valid = 2'b00;
    n = 0;
    while (!bus_if.rsp_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".lat"},   n + 1,               e_lat);
    chk({tag, ".id"},    bus_if.rsp_id,       id);
    chk({tag, ".hi"},    bus_if.rsp_hi,       e_hi);
    chk({tag, ".lo"},    bus_if.rsp_lo,       e_lo);
    chk({tag, ".err"},   bus_if.rsp_err,      e_err);
    chk({tag, ".uflow"}, bus_if.rsp_uflow,    e_uflow);
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
    chk({tag, ".done"},  bus_if.rsp_valid,    1'b0);
  endtask

  initial begin
    int n;
    int ng;
    logic gnt [4];
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_if.req_valid = 2'b11;
    bus_if.req_op    = '0;
    bus_if.req_a     = '0;
    bus_if.req_b     = '0;
    bus_if.rsp_ready = 1'b0;

    // Outputs held at zero through reset even with both requesters valid.
    step();
    step();
    chk("rst.req_ready", bus_if.req_ready, 2'b00);
    chk("rst.rsp_valid", bus_if.rsp_valid, 1'b0);
    chk("rst.rsp_data",  {bus_if.rsp_id, bus_if.rsp_hi, bus_if.rsp_lo}, 31'd0);
    chk("rst.flags",     {bus_if.rsp_uflow, bus_if.rsp_err}, 2'b00);

    // Round-robin with both requesters valid and responses drained at once.
    rst = 1'b0;
    bus_if.rsp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      if (bus_if.req_ready != 2'b00) begin
        gnt[ng] = bus_if.req_ready[1];
        ng++;
      end
      step();
    end
    chk("arb.count", ng, 4);
    chk("arb.g0", gnt[0], 1'b0);
    chk("arb.g1", gnt[1], 1'b1);
    chk("arb.g2", gnt[2], 1'b0);
    chk("arb.g3", gnt[3], 1'b1);
    bus_if.req_valid = 2'b00;
    repeat (6) step();
    bus_if.rsp_ready = 1'b0;

    // A stalled response must block any new grant.
    bus_if.req_valid = 2'b11;
    n = 0;
    while (!bus_if.rsp_valid && n < 20) begin
      step();
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      step();
      chk("hold.req_ready", bus_if.req_ready, 2'b00);
      chk("hold.rsp_valid", bus_if.rsp_valid, 1'b1);
    end
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.req_valid = 2'b00;
    bus_if.rsp_ready = 1'b0;
    repeat (3) step();

    // Arithmetic vectors.
    do_op("add",     1'b0, 2'd0, 30'h0000_0001, 15'h7FFE, 15'h0000, 15'h7FFF, 1'b0, 1'b0, 2);
    do_op("add_eac", 1'b1, 2'd0, 30'h0000_7FFE, 15'h7FFE, 15'h0000, 15'h7FFD, 1'b0, 1'b0, 2);
    do_op("sub",     1'b1, 2'd1, 30'h0000_0005, 15'h0003, 15'h0000, 15'h0002, 1'b0, 1'b0, 2);
    do_op("sub_nz",  1'b0, 2'd1, 30'h0000_0005, 15'h0005, 15'h0000, 15'h7FFF, 1'b0, 1'b0, 2);
    do_op("mul_neg", 1'b1, 2'd2, 30'h0000_0003, 15'h7FFD, 15'h7FFF, 15'h7FF9, 1'b0, 1'b0, 3);
    do_op("mul_pos", 1'b0, 2'd2, 30'h0000_0100, 15'h0200, 15'h0004, 15'h0000, 1'b0, 1'b0, 3);
    do_op("mul_nz",  1'b1, 2'd2, 30'h0000_0005, 15'h7FFF, 15'h0000, 15'h0000, 1'b0, 1'b0, 3);
`ifdef AGC_ALU_SEQ_DIV_EN
    do_op("div",     1'b0, 2'd3, 30'h0000_0007, 15'h0002, 15'h0003, 15'h0001, 1'b0, 1'b0, 5);
    do_op("div_neg", 1'b1, 2'd3, 30'h3FFF_FFF8, 15'h0002, 15'h7FFC, 15'h7FFE, 1'b0, 1'b0, 5);
`else
    do_op("div",     1'b0, 2'd3, 30'h0000_0007, 15'h0002, 15'h0000, 15'h0000, 1'b1, 1'b0, 1);
    do_op("div_neg", 1'b1, 2'd3, 30'h3FFF_FFF8, 15'h0002, 15'h0000, 15'h0000, 1'b1, 1'b0, 1);
`endif
    do_op("div_mz",  1'b0, 2'd3, 30'h0000_0007, 15'h7FFF, 15'h0000, 15'h0000, 1'b1, 1'b0, 1);
    do_op("div_pz",  1'b1, 2'd3, 30'h0000_0007, 15'h0000, 15'h0000, 15'h0000, 1'b1, 1'b0, 1);

    // Reset in the middle of a DIV from requester 0 (which moved the pointer to 1).
    bus_if.req_valid[0] = 1'b1;
    bus_if.req_op[0]    = 2'd3;
    bus_if.req_a[0]     = 30'h0000_0007;
    bus_if.req_b[0]     = 15'h0002;
    n = 0;
    while (!bus_if.req_ready[0] && n < 20) begin
      step();
      n++;
    end
    step();
    bus_if.req_valid = 2'b00;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.rsp_valid", bus_if.rsp_valid, 1'b0);
    chk("mid_rst.rsp_err",   bus_if.rsp_err,   1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.req_valid = 2'b11;
    bus_if.rsp_ready = 1'b1;
    n = 0;
    while (bus_if.req_ready == 2'b00 && n < 20) begin
      step();
      n++;
    end
    chk("mid_rst.grant", bus_if.req_ready, 2'b01);
    bus_if.req_valid = 2'b00;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
